// File: rtl/uart_bus_loader_pkg.sv
// Shared constants and helpers for the UART boot loader: frame opcodes,
// parser/receiver state encodings and bit-timing / timeout derivations.
package uart_bus_loader_pkg;

   localparam logic [7:0] OP_HOLD  = 8'h3C;
   localparam logic [7:0] OP_RUN   = 8'hC3;
   localparam logic [7:0] OP_WRITE = 8'hA5;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ADDR  = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_CHK   = 3'd3;
   localparam logic [2:0] ST_ISSUE = 3'd4;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   function automatic int timeout_clks(input int clk_freq, input int timeout_ms);
      return (clk_freq / 1000) * timeout_ms;
   endfunction

endpackage

// File: rtl/uart_bus_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, start-glitch rejection, centre sampling
// and stop-bit check. byte_valid / frame_err are single-cycle strobes.
module uart_rx
   import uart_bus_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   logic          s1_q, s2_q, prev_q;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      case (state_q)
         RX_IDLE: begin
            if (prev_q && !s2_q) begin
               state_d = RX_START;
               cnt_d   = '0;
            end
         end
         RX_START: begin
            // A start bit that is high again at half-bit was only a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = s2_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {s2_q, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = RX_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            if (cnt_q == BIT_LAST) state_d = RX_IDLE;
            else                   cnt_d   = cnt_q + CW'(1);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         s1_q    <= rx;
         s2_q    <= s1_q;
         prev_q  <= s2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   assign rx_byte    = shift_q;
   assign byte_valid = (state_q == RX_STOP) && (cnt_q == BIT_LAST) &&  s2_q;
   assign frame_err  = (state_q == RX_STOP) && (cnt_q == BIT_LAST) && !s2_q;

endmodule

// File: rtl/uart_bus_loader.sv
// UART boot loader acting as a word-write bus initiator while holding the CPU.
// Optional 9th-byte XOR checksum on WRITE frames: define UART_LOADER_CHECKSUM_EN.
module uart_bus_loader
   import uart_bus_loader_pkg::*;
#(
   parameter int CLK_FREQ      = 100000000,
   parameter int BAUD_RATE     = 115200,
   parameter int TIMEOUT_MS    = 50,
   parameter bit HOLD_ON_RESET = 1'b0,
   parameter int WL            = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          uart_rx,
   output logic          cmd_valid,
   input  logic          cmd_ready,
   output logic          cmd_payload_wr,
   output logic [WL-1:0] cmd_payload_address,
   output logic [WL-1:0] cmd_payload_data,
   output logic [1:0]    cmd_payload_size,
   output logic          cpu_hold,
   output logic          load_err,
   output logic [15:0]   word_count
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int TO_CLKS      = timeout_clks(CLK_FREQ, TIMEOUT_MS);
   localparam int TW           = $clog2(TO_CLKS + 1);
   localparam logic [TW-1:0] TO_RELOAD = TW'(TO_CLKS - 1);

   logic [7:0] rx_byte;
   logic       rx_valid, rx_ferr;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .reset      (reset),
      .rx         (uart_rx),
      .rx_byte    (rx_byte),
      .byte_valid (rx_valid),
      .frame_err  (rx_ferr)
   );

   logic [7:0]    buf_q, buf_d;
   logic          buf_full_q, buf_full_d;
   logic [2:0]    state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [WL-1:0] addr_q, addr_d;
   logic [WL-1:0] data_q, data_d;
   logic          cpu_hold_q, cpu_hold_d;
   logic          load_err_q, load_err_d;
   logic [15:0]   word_count_q, word_count_d;
   logic [TW-1:0] to_q, to_d;
   logic          consume;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [7:0]    chk_q, chk_d;
`endif

   always_comb begin
      buf_d        = buf_q;
      buf_full_d   = buf_full_q;
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      data_d       = data_q;
      cpu_hold_d   = cpu_hold_q;
      load_err_d   = 1'b0;
      word_count_d = word_count_q;
      to_d         = to_q;
`ifdef UART_LOADER_CHECKSUM_EN
      chk_d        = chk_q;
`endif
      // The buffered byte waits while a command is outstanding.
      consume = buf_full_q && (state_q != ST_ISSUE);

      if (consume) begin
         buf_full_d = 1'b0;
         to_d       = TO_RELOAD;
`ifdef UART_LOADER_CHECKSUM_EN
         chk_d      = chk_q ^ buf_q;
`endif
         case (state_q)
            ST_IDLE: begin
               case (buf_q)
                  OP_HOLD: begin
                     cpu_hold_d   = 1'b1;
                     word_count_d = '0;
                  end
                  OP_RUN:   cpu_hold_d = 1'b0;
                  OP_WRITE: begin
                     state_d = ST_ADDR;
                     cnt_d   = '0;
`ifdef UART_LOADER_CHECKSUM_EN
                     chk_d   = buf_q;
`endif
                  end
                  default:  load_err_d = 1'b1;
               endcase
            end
            ST_ADDR: begin
               addr_d[{cnt_q, 3'b000} +: 8] = buf_q;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = ST_DATA;
            end
            ST_DATA: begin
               data_d[{cnt_q, 3'b000} +: 8] = buf_q;
               cnt_d = cnt_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
               if (cnt_q == 2'd3) state_d = ST_CHK;
`else
               if (cnt_q == 2'd3) state_d = ST_ISSUE;
`endif
            end
`ifdef UART_LOADER_CHECKSUM_EN
            ST_CHK: begin
               if (buf_q == chk_q) begin
                  state_d = ST_ISSUE;
               end else begin
                  state_d    = ST_IDLE;
                  load_err_d = 1'b1;
               end
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q == ST_ADDR || state_q == ST_DATA || state_q == ST_CHK) begin
         if (to_q == '0) begin
            state_d    = ST_IDLE;
            load_err_d = 1'b1;
         end else begin
            to_d = to_q - TW'(1);
         end
      end

      if (state_q == ST_ISSUE && cmd_ready) begin
         state_d = ST_IDLE;
         if (word_count_q != 16'hFFFF) word_count_d = word_count_q + 16'd1;
      end

      // Overrun keeps the older byte and abandons any frame in progress.
      if (rx_valid) begin
         if (buf_full_q && !consume) begin
            load_err_d = 1'b1;
            state_d    = ST_IDLE;
         end else begin
            buf_d      = rx_byte;
            buf_full_d = 1'b1;
         end
      end
      if (rx_ferr) load_err_d = 1'b1;

      addr_d[1:0] = 2'b00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_q        <= '0;
         buf_full_q   <= 1'b0;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         cpu_hold_q   <= HOLD_ON_RESET;
         load_err_q   <= 1'b0;
         word_count_q <= '0;
         to_q         <= TO_RELOAD;
`ifdef UART_LOADER_CHECKSUM_EN
         chk_q        <= '0;
`endif
      end else begin
         buf_q        <= buf_d;
         buf_full_q   <= buf_full_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         cpu_hold_q   <= cpu_hold_d;
         load_err_q   <= load_err_d;
         word_count_q <= word_count_d;
         to_q         <= to_d;
`ifdef UART_LOADER_CHECKSUM_EN
         chk_q        <= chk_d;
`endif
      end
   end

   assign cmd_valid           = (state_q == ST_ISSUE);
   assign cmd_payload_wr      = 1'b1;
   assign cmd_payload_address = addr_q;
   assign cmd_payload_data    = data_q;
   assign cmd_payload_size    = 2'b10;
   assign cpu_hold            = cpu_hold_q;
   assign load_err            = load_err_q;
   assign word_count          = word_count_q;

endmodule
